hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage pipeline (fetch, decode, execute, memory, writeback). It generates the forwarding selects, fetch/decode stalls, decode/execute flushes and the fetch redirect gate. It adds multi-cycle data-memory wait handling through a small state machine, and saturating performance counters. It sits beside the stage modules and drives their stall/flush enables, replacing the hazard-free connection of the stages.

## Interface
Parameters:
- REG_AW, 5, register address width
- MEM_LAT, 0, extra data-memory wait cycles per memory op (0..15); 0 disables the wait FSM
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- Rs1D, Rs2D  in  REG_AW  source registers of the instruction in decode
- Rs1E, Rs2E  in  REG_AW  source registers of the instruction in execute
- RD_E, RD_M, RDW  in  REG_AW  destination registers in execute, memory and writeback
- ResultSrcE  in  1  execute instruction is a load
- RegWriteM, RegWriteW  in  1  register-write enables in memory and writeback
- MemReqM  in  1  memory-stage instruction is a load or a store
- PCSrcE  in  1  branch taken, resolved in execute
- perf_clr  in  1  synchronous clear of all counters
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 = register file, 01 = ResultW, 10 = ALU_ResultM
- StallF, StallD, StallE, StallM  out  1  hold the PC / pipeline registers
- FlushD, FlushE, FlushW  out  1  load a bubble into the pipeline register
- RedirectF  out  1  gated PCSrcE to the fetch PC mux
- busy  out  1  wait FSM not in RUN
- lu_cnt, mem_cnt, fl_cnt  out  CNT_W  load-use stall, memory-wait stall and branch-flush event counts

## Operation
- Forwarding (combinational, per operand; ForwardBE is identical using Rs2E):
  - 10 when RegWriteM, RD_M≠0 and RD_M==Rs1E.
  - Otherwise 01 when RegWriteW, RDW≠0 and RDW==Rs1E.
  - Otherwise 00.
  - The memory-stage match has priority over the writeback match.
- Load-use (lw): lw = ResultSrcE & RD_E≠0 & (RD_E==Rs1D | RD_E==Rs2D).
- Wait FSM states:
  - RUN. memstall = MemReqM & (MEM_LAT>0), combinational. On memstall: next state WAIT, wcnt ← MEM_LAT−1.
  - WAIT. memstall = (wcnt≠0). While wcnt≠0: wcnt decrements. When wcnt==0: memstall = 0 and next state RUN.
  - Total memstall cycles per memory op = MEM_LAT exactly.
  - The first RUN cycle after WAIT evaluates MemReqM afresh, so back-to-back memory ops each wait MEM_LAT.
- Output priority, highest first:
  - memstall: StallF = StallD = StallE = StallM = 1, FlushW = 1, every other flush 0, RedirectF = 0.
  - PCSrcE: FlushD = FlushE = 1, RedirectF = 1, StallF = StallD = 0. lw is ignored because it is on the wrong path.
  - lw: StallF = StallD = 1, FlushE = 1.
  - Otherwise all stall/flush outputs 0; RedirectF = PCSrcE.
- Counters saturate at 2^CNT_W−1 and increment by at most 1 per cycle:
  - lu_cnt counts cycles in which the lw branch of the priority is taken.
  - mem_cnt counts memstall cycles.
  - fl_cnt counts cycles in which the PCSrcE branch is taken.
  - perf_clr zeroes all counters and wins over any increment in the same cycle.
- REG_AW only sets comparator widths. Register 0 never forwards and never causes a stall.

## Timing
- Reset:
  - While rst = 1: state ← RUN, wcnt ← 0, all counters ← 0.
  - While rst = 1, all Stall*/Flush*/RedirectF/busy outputs are forced to 0; ForwardAE and ForwardBE are forced to 00.
  - Reset mid-WAIT abandons the wait immediately.
- Forwarding, lw stalls, flushes and the first memstall cycle are combinational from the inputs in the same cycle, with zero latency.
- busy is registered: it is 1 from the cycle after WAIT is entered through the final WAIT cycle where wcnt==0.
- A branch resolving while memstall = 1 is held: E is frozen, PCSrcE stays valid, and the redirect is issued in the first cycle memstall = 0.
- A lw stall asserts for exactly one cycle per load-use pair. The bubble leaves E on the next edge, so the hazard clears.

## Test plan
- add x5 in M, add x6 in W, instruction in E reads x5 and x6 → ForwardAE = 10, ForwardBE = 01. Repeat with RD_M = RDW = 0 → both 00.
- lw x3 in E, decode reads x3, MEM_LAT = 0 → StallF = StallD = FlushE = 1 for one cycle, lu_cnt = 1. Repeat with PCSrcE = 1 in the same cycle → FlushD = FlushE = 1, StallF = 0, fl_cnt = 1, lu_cnt = 0.
- MEM_LAT = 3, single store in M → stalls and FlushW high for exactly 3 cycles, busy high cycles 2–4, mem_cnt = 3. Two consecutive memory ops → 6 stall cycles total.
- MEM_LAT = 2, PCSrcE = 1 during the wait → RedirectF = 0 for 2 cycles, then 1. FlushD and FlushE pulse once after the wait.
- rst asserted in the second WAIT cycle → the next cycle shows state RUN, busy = 0, counters 0, no stall.
- CNT_W = 2, 5 lw events → lu_cnt saturates at 3. perf_clr together with an event → lu_cnt = 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: register
// addresses and write enables coming from the stages, and the
// forwarding selects plus stall/flush/redirect controls going back.
interface hazard_ctrl_if #(
   parameter int REG_AW = 5
) ();

   // Source registers of the instructions in decode and execute
   logic [REG_AW-1:0] Rs1D;
   logic [REG_AW-1:0] Rs2D;
   logic [REG_AW-1:0] Rs1E;
   logic [REG_AW-1:0] Rs2E;

   // Destination registers in execute, memory and writeback
   logic [REG_AW-1:0] RD_E;
   logic [REG_AW-1:0] RD_M;
   logic [REG_AW-1:0] RDW;

   // Stage qualifiers
   logic              ResultSrcE;
   logic              RegWriteM;
   logic              RegWriteW;
   logic              MemReqM;
   logic              PCSrcE;

   // Controls back to the datapath
   logic [1:0]        ForwardAE;
   logic [1:0]        ForwardBE;
   logic              StallF;
   logic              StallD;
   logic              StallE;
   logic              StallM;
   logic              FlushD;
   logic              FlushE;
   logic              FlushW;
   logic              RedirectF;

   // Pipeline stages drive the addresses and consume the controls
   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RDW,
      output ResultSrcE, RegWriteM, RegWriteW, MemReqM, PCSrcE,
      input  ForwardAE, ForwardBE,
      input  StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushW, RedirectF
   );

   // The hazard controller observes the stages and drives the controls
   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RDW,
      input  ResultSrcE, RegWriteM, RegWriteW, MemReqM, PCSrcE,
      output ForwardAE, ForwardBE,
      output StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushW, RedirectF
   );

endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Produces ALU operand forwarding selects, load-use stalls, branch
// flushes, a multi-cycle data-memory wait (small FSM) and saturating
// event counters. Everything except the wait state and the counters is
// combinational so hazards are resolved in the cycle they appear.
module hazard_ctrl #(
   parameter int REG_AW  = 5,
   parameter int MEM_LAT = 0,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   hazard_ctrl_if.slave     pipe,
   input  logic             perf_clr,
   output logic             busy,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] mem_cnt,
   output logic [CNT_W-1:0] fl_cnt
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   // A latency of zero removes the wait path entirely; the counter is
   // loaded with latency-1 because the RUN cycle that launches the wait
   // already counts as the first stall cycle.
   localparam bit         MEM_EN = (MEM_LAT > 0);
   localparam logic [3:0] LAT_M1 = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

   // ------------------------------------------------------------------
   // Operand views, indexed so both operands share one generate body
   // ------------------------------------------------------------------
   logic [REG_AW-1:0] rs_d [2];
   logic [REG_AW-1:0] rs_e [2];
   logic [1:0]        fwd_sel [2];
   logic [1:0]        lw_hit;

   assign rs_d[0] = pipe.Rs1D;
   assign rs_d[1] = pipe.Rs2D;
   assign rs_e[0] = pipe.Rs1E;
   assign rs_e[1] = pipe.Rs2E;

   // ------------------------------------------------------------------
   // Forwarding and load-use detection per operand
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      logic hit_m;
      logic hit_w;

      // x0 is hard-wired to zero, so a write to it must never be bypassed
      assign hit_m = pipe.RegWriteM && (pipe.RD_M != '0) && (pipe.RD_M == rs_e[gi]);
      assign hit_w = pipe.RegWriteW && (pipe.RDW  != '0) && (pipe.RDW  == rs_e[gi]);

      // The memory stage holds the younger result, so it wins over writeback
      assign fwd_sel[gi] = rst   ? 2'b00 :
                           hit_m ? 2'b10 :
                           hit_w ? 2'b01 : 2'b00;

      // Decode operand matches the load destination sitting in execute
      assign lw_hit[gi] = (pipe.RD_E == rs_d[gi]);
   end

   assign pipe.ForwardAE = fwd_sel[0];
   assign pipe.ForwardBE = fwd_sel[1];

   logic lw;
   assign lw = pipe.ResultSrcE && (pipe.RD_E != '0) && (|lw_hit);

   // ------------------------------------------------------------------
   // Memory wait FSM
   // ------------------------------------------------------------------
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t     state_reg;
   state_t     state_next;
   logic [3:0] wcnt_reg;
   logic [3:0] wcnt_next;
   logic       memstall_raw;
   logic       memstall;

   // State and wait-count registers; reset drops any wait in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_RUN;
         wcnt_reg  <= 4'd0;
      end else begin
         state_reg <= state_next;
         wcnt_reg  <= wcnt_next;
      end
   end

   // Next state and memstall: the launching RUN cycle stalls at once,
   // then WAIT covers the remaining cycles and releases when wcnt hits 0
   always_comb begin
      state_next   = state_reg;
      wcnt_next    = wcnt_reg;
      memstall_raw = 1'b0;
      case (state_reg)
         ST_RUN: begin
            if (pipe.MemReqM && MEM_EN) begin
               memstall_raw = 1'b1;
               state_next   = ST_WAIT;
               wcnt_next    = LAT_M1;
            end
         end
         ST_WAIT: begin
            if (wcnt_reg != 4'd0) begin
               memstall_raw = 1'b1;
               wcnt_next    = wcnt_reg - 4'd1;
            end else begin
               // Release cycle: the op leaves M on this edge, and the next
               // RUN cycle looks at MemReqM afresh for a following op
               state_next = ST_RUN;
            end
         end
         default: begin
            state_next = ST_RUN;
            wcnt_next  = 4'd0;
         end
      endcase
   end

   assign memstall = memstall_raw && !rst;
   assign busy     = (state_reg == ST_WAIT) && !rst;

   // ------------------------------------------------------------------
   // Stall / flush / redirect priority
   // ------------------------------------------------------------------
   logic stall_f;
   logic stall_d;
   logic stall_e;
   logic stall_m;
   logic flush_d;
   logic flush_e;
   logic flush_w;
   logic redirect;
   logic lu_evt;
   logic fl_evt;

   // Memory wait freezes everything (a resolved branch stays parked in E
   // and redirects once the wait ends); a taken branch beats a load-use
   // stall because the dependent instruction is on the wrong path
   always_comb begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      stall_m  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      flush_w  = 1'b0;
      redirect = 1'b0;
      lu_evt   = 1'b0;
      fl_evt   = 1'b0;
      if (rst) begin
         // all controls held inactive
      end else if (memstall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (pipe.PCSrcE) begin
         flush_d  = 1'b1;
         flush_e  = 1'b1;
         redirect = 1'b1;
         fl_evt   = 1'b1;
      end else if (lw) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
         lu_evt  = 1'b1;
      end
   end

   assign pipe.StallF    = stall_f;
   assign pipe.StallD    = stall_d;
   assign pipe.StallE    = stall_e;
   assign pipe.StallM    = stall_m;
   assign pipe.FlushD    = flush_d;
   assign pipe.FlushE    = flush_e;
   assign pipe.FlushW    = flush_w;
   assign pipe.RedirectF = redirect;

   // ------------------------------------------------------------------
   // Saturating event counters: 0 = load-use, 1 = memory wait, 2 = flush
   // ------------------------------------------------------------------
   logic [2:0]       cnt_evt;
   logic [CNT_W-1:0] cnt_val [3];

   assign cnt_evt = {fl_evt, memstall, lu_evt};

   for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      // Clear has priority over counting; stick at all-ones when full
      always_ff @(posedge clk) begin
         if (rst || perf_clr) begin
            cnt_reg <= '0;
         end else if (cnt_evt[gi] && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end

      assign cnt_val[gi] = cnt_reg;
   end

   assign lu_cnt  = cnt_val[0];
   assign mem_cnt = cnt_val[1];
   assign fl_cnt  = cnt_val[2];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Three instances share one stimulus:
//   a: MEM_LAT=0, CNT_W=2  (combinational hazards, counter saturation)
//   b: MEM_LAT=3, CNT_W=16 (memory wait, reset during wait)
//   c: MEM_LAT=2, CNT_W=16 (branch parked behind a wait, event counts)
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic perf_clr;

   logic [4:0] rs1d, rs2d, rs1e, rs2e, rd_e, rd_m, rdw;
   logic       lw_e, rw_m, rw_w, mem_req, pc_src;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.REG_AW(5)) bus_a ();
   hazard_ctrl_if #(.REG_AW(5)) bus_b ();
   hazard_ctrl_if #(.REG_AW(5)) bus_c ();

   assign bus_a.Rs1D = rs1d;  assign bus_b.Rs1D = rs1d;  assign bus_c.Rs1D = rs1d;
   assign bus_a.Rs2D = rs2d;  assign bus_b.Rs2D = rs2d;  assign bus_c.Rs2D = rs2d;
   assign bus_a.Rs1E = rs1e;  assign bus_b.Rs1E = rs1e;  assign bus_c.Rs1E = rs1e;
   assign bus_a.Rs2E = rs2e;  assign bus_b.Rs2E = rs2e;  assign bus_c.Rs2E = rs2e;
   assign bus_a.RD_E = rd_e;  assign bus_b.RD_E = rd_e;  assign bus_c.RD_E = rd_e;
   assign bus_a.RD_M = rd_m;  assign bus_b.RD_M = rd_m;  assign bus_c.RD_M = rd_m;
   assign bus_a.RDW  = rdw;   assign bus_b.RDW  = rdw;   assign bus_c.RDW  = rdw;
   assign bus_a.ResultSrcE = lw_e;    assign bus_b.ResultSrcE = lw_e;    assign bus_c.ResultSrcE = lw_e;
   assign bus_a.RegWriteM  = rw_m;    assign bus_b.RegWriteM  = rw_m;    assign bus_c.RegWriteM  = rw_m;
   assign bus_a.RegWriteW  = rw_w;    assign bus_b.RegWriteW  = rw_w;    assign bus_c.RegWriteW  = rw_w;
   assign bus_a.MemReqM    = mem_req; assign bus_b.MemReqM    = mem_req; assign bus_c.MemReqM    = mem_req;
   assign bus_a.PCSrcE     = pc_src;  assign bus_b.PCSrcE     = pc_src;  assign bus_c.PCSrcE     = pc_src;

   logic        busy_a, busy_b, busy_c;
   logic [1:0]  lu_a, mem_a, fl_a;
   logic [15:0] lu_b, mem_b, fl_b;
   logic [15:0] lu_c, mem_c, fl_c;

   hazard_ctrl #(.REG_AW(5), .MEM_LAT(0), .CNT_W(2)) dut_a (
      .clk(clk), .rst(rst), .pipe(bus_a), .perf_clr(perf_clr),
      .busy(busy_a), .lu_cnt(lu_a), .mem_cnt(mem_a), .fl_cnt(fl_a)
   );
   hazard_ctrl #(.REG_AW(5), .MEM_LAT(3), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .pipe(bus_b), .perf_clr(perf_clr),
      .busy(busy_b), .lu_cnt(lu_b), .mem_cnt(mem_b), .fl_cnt(fl_b)
   );
   hazard_ctrl #(.REG_AW(5), .MEM_LAT(2), .CNT_W(16)) dut_c (
      .clk(clk), .rst(rst), .pipe(bus_c), .perf_clr(perf_clr),
      .busy(busy_c), .lu_cnt(lu_c), .mem_cnt(mem_c), .fl_cnt(fl_c)
   );

   // Control bundle {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,RedirectF}
   logic [7:0] ctl_a, ctl_b, ctl_c;
   assign ctl_a = {bus_a.StallF, bus_a.StallD, bus_a.StallE, bus_a.StallM,
                   bus_a.FlushD, bus_a.FlushE, bus_a.FlushW, bus_a.RedirectF};
   assign ctl_b = {bus_b.StallF, bus_b.StallD, bus_b.StallE, bus_b.StallM,
                   bus_b.FlushD, bus_b.FlushE, bus_b.FlushW, bus_b.RedirectF};
   assign ctl_c = {bus_c.StallF, bus_c.StallD, bus_c.StallE, bus_c.StallM,
                   bus_c.FlushD, bus_c.FlushE, bus_c.FlushW, bus_c.RedirectF};

   localparam logic [7:0] C_NONE = 8'h00;
   localparam logic [7:0] C_LW   = 8'hC4;
   localparam logic [7:0] C_BR   = 8'h0D;
   localparam logic [7:0] C_MEM  = 8'hF2;

   typedef struct {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rd_e, rd_m, rdw;
      logic       lw_e, rw_m, rw_w, pc_src;
      logic [1:0] fa, fb;
      logic [7:0] ctl;
   } vec_t;

   vec_t vecs [13];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic idle();
      rs1d = 5'd0; rs2d = 5'd0; rs1e = 5'd0; rs2e = 5'd0;
      rd_e = 5'd0; rd_m = 5'd0; rdw  = 5'd0;
      lw_e = 1'b0; rw_m = 1'b0; rw_w = 1'b0;
      mem_req = 1'b0; pc_src = 1'b0; perf_clr = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      rs1d = v.rs1d; rs2d = v.rs2d; rs1e = v.rs1e; rs2e = v.rs2e;
      rd_e = v.rd_e; rd_m = v.rd_m; rdw  = v.rdw;
      lw_e = v.lw_e; rw_m = v.rw_m; rw_w = v.rw_w; pc_src = v.pc_src;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;

      // rs1d rs2d rs1e rs2e rd_e rd_m rdw  lw rwm rww pc   fa    fb    ctl
      vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd6, 5'd0, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b01, C_NONE};
      vecs[1]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, C_NONE};
      vecs[2]  = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, C_NONE};
      vecs[3]  = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, C_NONE};
      vecs[4]  = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
      vecs[5]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_LW};
      vecs[6]  = '{5'd1, 5'd4, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_LW};
      vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
      vecs[8]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
      vecs[9]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, C_BR};
      vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, C_BR};
      vecs[11] = '{5'd2, 5'd9, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_NONE};
      vecs[12] = '{5'd0, 5'd0, 5'd5, 5'd9, 5'd0, 5'd9, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10, C_NONE};

      // Reset state: hazard-looking inputs must not leak through during reset
      idle();
      rst = 1'b1;
      rs1e = 5'd5; rd_m = 5'd5; rw_m = 1'b1; pc_src = 1'b1; mem_req = 1'b1;
      @(negedge clk);
      chk("rst_fwd_a", 32'(bus_a.ForwardAE), 32'd0);
      chk("rst_ctl_b", 32'(ctl_b), 32'(C_NONE));
      chk("rst_busy_b", 32'(busy_b), 32'd0);
      tick();
      tick();
      idle();
      rst = 1'b0;
      chk("rst_cnt_c", 32'(lu_c) + 32'(mem_c) + 32'(fl_c), 32'd0);

      // Table vectors on the zero-latency instance
      for (int i = 0; i < 13; i++) begin
         apply(vecs[i]);
         @(negedge clk);
         chk($sformatf("vec%0d_fa", i),  32'(bus_a.ForwardAE), 32'(vecs[i].fa));
         chk($sformatf("vec%0d_fb", i),  32'(bus_a.ForwardBE), 32'(vecs[i].fb));
         chk($sformatf("vec%0d_ctl", i), 32'(ctl_a), 32'(vecs[i].ctl));
         tick();
      end

      // Single load-use: one stall cycle, one lu event
      do_reset();
      apply(vecs[5]);
      tick();
      idle();
      @(negedge clk);
      chk("lu_once_ctl", 32'(ctl_a), 32'(C_NONE));
      chk("lu_once_cnt", 32'(lu_c), 32'd1);

      // Load-use with taken branch: flush wins, counted as a flush
      do_reset();
      apply(vecs[9]);
      tick();
      idle();
      chk("lubr_fl_cnt", 32'(fl_c), 32'd1);
      chk("lubr_lu_cnt", 32'(lu_c), 32'd0);

      // MEM_LAT=3 single store: stall cycles 1-3, busy cycles 2-4
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         mem_req = (i <= 4);
         @(negedge clk);
         chk($sformatf("st_c%0d_ctl", i), 32'(ctl_b), (i <= 3) ? 32'(C_MEM) : 32'(C_NONE));
         chk($sformatf("st_c%0d_busy", i), 32'(busy_b), (i >= 2 && i <= 4) ? 32'd1 : 32'd0);
         tick();
      end
      chk("st_mem_cnt", 32'(mem_b), 32'd3);

      // Back-to-back memory ops: 3 + 3 stall cycles
      do_reset();
      stalls = 0;
      for (int i = 1; i <= 12; i++) begin
         mem_req = (i <= 8);
         @(negedge clk);
         if (ctl_b[7]) stalls++;
         tick();
      end
      chk("b2b_stalls", 32'(stalls), 32'd6);
      chk("b2b_mem_cnt", 32'(mem_b), 32'd6);

      // MEM_LAT=2 with a branch resolved during the wait
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         mem_req = (i <= 3);
         pc_src  = (i <= 3);
         @(negedge clk);
         chk($sformatf("brw_c%0d_ctl", i), 32'(ctl_c),
             (i <= 2) ? 32'(C_MEM) : (i == 3) ? 32'(C_BR) : 32'(C_NONE));
         tick();
      end
      chk("brw_fl_cnt", 32'(fl_c), 32'd1);
      chk("brw_mem_cnt", 32'(mem_c), 32'd2);

      // Reset in the second WAIT cycle abandons the wait
      do_reset();
      mem_req = 1'b1;
      @(negedge clk);
      chk("rw_c1_ctl", 32'(ctl_b), 32'(C_MEM));
      tick();
      @(negedge clk);
      chk("rw_c2_busy", 32'(busy_b), 32'd1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rw_c3_ctl", 32'(ctl_b), 32'(C_NONE));
      chk("rw_c3_busy", 32'(busy_b), 32'd0);
      tick();
      rst = 1'b0;
      mem_req = 1'b0;
      @(negedge clk);
      chk("rw_c4_busy", 32'(busy_b), 32'd0);
      chk("rw_c4_ctl", 32'(ctl_b), 32'(C_NONE));
      chk("rw_c4_cnt", 32'(mem_b), 32'd0);
      tick();

      // CNT_W=2 saturation, then clear beating a simultaneous event
      do_reset();
      apply(vecs[5]);
      tick();
      tick();
      chk("sat_2", 32'(lu_a), 32'd2);
      tick();
      tick();
      tick();
      chk("sat_5", 32'(lu_a), 32'd3);
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      idle();
      chk("clr_evt", 32'(lu_a), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
